// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module : mem_arbiter_pkg
// Brief  : Shared types for the LC-3b memory-port arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    typedef enum logic [1:0] {
        arb_idle    = 2'd0,
        arb_grant_i = 2'd1,
        arb_grant_d = 2'd2
    } lc3b_arb_state;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module : mem_arbiter_if
// Brief  : Requester and physical-memory signals around the arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
);
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    logic              proto_err;

    modport slave (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata,
               pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
               pmem_read, pmem_write, pmem_address, pmem_wdata, proto_err
    );

    modport master (
        output i_read, i_address, d_read, d_write, d_address, d_wdata,
               pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
               pmem_read, pmem_write, pmem_address, pmem_wdata, proto_err
    );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter_select.sv
// ============================================================================
// Module : arb_select
// Brief  : Data-first winner choice with bounded instruction-side starvation.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_select
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          idle,
    input  wire logic          i_req,
    input  wire logic          d_req,
    output lc3b_arb_state      next_grant,
    output logic [3:0]         streak
);

    localparam logic [3:0] C_MAX = 4'(MAX_D_STREAK);

    logic [3:0] streak_q, streak_d;

    always_comb begin
        next_grant = arb_idle;
        if (i_req && d_req) begin
            next_grant = (streak_q < C_MAX) ? arb_grant_d : arb_grant_i;
        end else if (d_req) begin
            next_grant = arb_grant_d;
        end else if (i_req) begin
            next_grant = arb_grant_i;
        end
    end

    // The streak only moves on the cycle a grant is actually taken from IDLE.
    always_comb begin
        streak_d = streak_q;
        if (idle) begin
            case (next_grant)
                arb_grant_d: begin
                    if (i_req) begin
                        streak_d = (streak_q < C_MAX) ? streak_q + 4'd1 : C_MAX;
                    end else begin
                        streak_d = 4'd0;
                    end
                end
                arb_grant_i: streak_d = 4'd0;
                default:     streak_d = streak_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak_q <= 4'd0;
        end else begin
            streak_q <= streak_d;
        end
    end

    assign streak = streak_q;

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module : mem_arbiter
// Brief  : Shares one physical memory port between I-side and D-side.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int LINE_W       = 128,
    parameter int MAX_D_STREAK = 4
) (
    input  wire logic     clk,
    input  wire logic     reset,
    mem_arbiter_if.slave  bus
);

    localparam logic [ADDR_W-1:0] C_ADDR_ZERO = '0;
    localparam logic [LINE_W-1:0] C_LINE_ZERO = '0;

    lc3b_arb_state state_q, state_d, next_grant;
    logic          proto_err_q, proto_err_d;
    logic          i_req, d_req, both_rw;
    logic [3:0]    streak_unused;

    assign i_req   = bus.i_read;
    assign d_req   = bus.d_read | bus.d_write;
    assign both_rw = bus.d_read & bus.d_write;

    // streak is exported for observation only; the winner choice already uses it.
    arb_select #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_sel (
        .clk        (clk),
        .reset      (reset),
        .idle       (state_q == arb_idle),
        .i_req      (i_req),
        .d_req      (d_req),
        .next_grant (next_grant),
        .streak     (streak_unused)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            arb_idle:    state_d = next_grant;
            arb_grant_i: if (bus.pmem_resp || !i_req) state_d = arb_idle;
            arb_grant_d: if (bus.pmem_resp || !d_req) state_d = arb_idle;
            default:     state_d = arb_idle;
        endcase
        proto_err_d = proto_err_q | (both_rw & (state_q != arb_grant_i));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= arb_idle;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_comb begin
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = C_ADDR_ZERO;
        bus.pmem_wdata   = C_LINE_ZERO;
        bus.i_resp       = 1'b0;
        bus.i_rdata      = C_LINE_ZERO;
        bus.d_resp       = 1'b0;
        bus.d_rdata      = C_LINE_ZERO;
        case (state_q)
            arb_grant_i: begin
                bus.pmem_read    = bus.i_read;
                bus.pmem_address = bus.i_address;
                bus.i_resp       = bus.pmem_resp;
                bus.i_rdata      = bus.pmem_rdata;
            end
            arb_grant_d: begin
                // Read wins when both strobes are raised.
                bus.pmem_read    = bus.d_read;
                bus.pmem_write   = bus.d_write & ~bus.d_read;
                bus.pmem_address = bus.d_address;
                bus.pmem_wdata   = bus.d_wdata;
                bus.d_resp       = bus.pmem_resp;
                bus.d_rdata      = bus.pmem_rdata;
            end
            default: ;
        endcase
    end

    assign bus.proto_err = proto_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module : tb_mem_arbiter
// Brief  : Directed and randomized checks of mem_arbiter against a rule model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int MAXS = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    mem_arbiter_if #(.ADDR_W(16), .LINE_W(128)) bus ();

    mem_arbiter #(
        .ADDR_W       (16),
        .LINE_W       (128),
        .MAX_D_STREAK (MAXS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk128(input string tag, input lc3b_line obs, input lc3b_line exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic resp_on(input lc3b_line rd);
        bus.pmem_rdata = rd;
        bus.pmem_resp  = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        lc3b_line a5  = {16{8'hA5}};
        lc3b_line w12 = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
        int       run = 0;

        bus.i_read = 0; bus.i_address = '0;
        bus.d_read = 0; bus.d_write = 0; bus.d_address = '0; bus.d_wdata = '0;
        bus.pmem_rdata = '0; bus.pmem_resp = 0;
        tick; tick;
        reset = 1'b0;
        tick;

        // Reset state
        chk1  ("rst_pmem_read",  bus.pmem_read,  1'b0);
        chk1  ("rst_pmem_write", bus.pmem_write, 1'b0);
        chk1  ("rst_i_resp",     bus.i_resp,     1'b0);
        chk1  ("rst_d_resp",     bus.d_resp,     1'b0);
        chk16 ("rst_pmem_addr",  bus.pmem_address, 16'h0);
        chk128("rst_pmem_wdata", bus.pmem_wdata, '0);
        chk128("rst_i_rdata",    bus.i_rdata,    '0);
        chk128("rst_d_rdata",    bus.d_rdata,    '0);
        chk1  ("rst_proto_err",  bus.proto_err,  1'b0);
        chk1  ("rst_idle",       dut.state_q == arb_idle, 1'b1);
        chk16 ("rst_streak",     16'(dut.u_sel.streak_q), 16'h0);

        // Single I read, memory answers on the third granted cycle
        bus.i_read = 1; bus.i_address = 16'h0040;
        tick;
        chk1 ("i_grant_read", bus.pmem_read, 1'b1);
        chk16("i_grant_addr", bus.pmem_address, 16'h0040);
        tick; tick;
        chk1 ("i_wait_resp", bus.i_resp, 1'b0);
        resp_on(a5);
        chk1  ("i_resp",        bus.i_resp,  1'b1);
        chk128("i_rdata",       bus.i_rdata, a5);
        chk1  ("i_d_resp_zero", bus.d_resp,  1'b0);
        tick;
        bus.pmem_resp = 0; bus.i_read = 0;
        tick;
        chk1("i_back_idle", dut.state_q == arb_idle, 1'b1);
        chk1("i_single_pulse", bus.i_resp, 1'b0);

        // Stray response in IDLE
        resp_on(a5);
        chk1("stray_i_resp", bus.i_resp, 1'b0);
        chk1("stray_d_resp", bus.d_resp, 1'b0);
        tick;
        bus.pmem_resp = 0;
        chk1("stray_idle", dut.state_q == arb_idle, 1'b1);

        // Simultaneous requests: data first, instruction next
        bus.i_read = 1; bus.i_address = 16'h0040;
        bus.d_read = 1; bus.d_address = 16'h1000;
        tick;
        chk16("sim_first_addr", bus.pmem_address, 16'h1000);
        resp_on(a5);
        chk1("sim_d_resp", bus.d_resp, 1'b1);
        chk1("sim_i_quiet", bus.i_resp, 1'b0);
        tick;
        bus.pmem_resp = 0; bus.d_read = 0;
        tick;
        chk16("sim_second_addr", bus.pmem_address, 16'h0040);
        chk1 ("sim_second_read", bus.pmem_read, 1'b1);
        resp_on(w12);
        chk128("sim_i_rdata", bus.i_rdata, w12);
        tick;
        bus.pmem_resp = 0; bus.i_read = 0;
        tick;

        // Starvation bound: both held, four D grants then one I grant
        bus.i_read = 1; bus.i_address = 16'h0040;
        bus.d_read = 1; bus.d_address = 16'h1000;
        for (int g = 0; g <= MAXS; g++) begin
            tick;
            chk16("starve_addr", bus.pmem_address, (g < MAXS) ? 16'h1000 : 16'h0040);
            chk16("starve_streak", 16'(dut.u_sel.streak_q), (g < MAXS) ? 16'(g + 1) : 16'h0);
            resp_on(a5);
            tick;
            bus.pmem_resp = 0;
        end
        bus.i_read = 0; bus.d_read = 0;
        tick;

        // Data write
        bus.d_write = 1; bus.d_address = 16'h2000; bus.d_wdata = w12;
        tick;
        chk1  ("wr_pmem_write", bus.pmem_write, 1'b1);
        chk1  ("wr_pmem_read",  bus.pmem_read,  1'b0);
        chk16 ("wr_addr",       bus.pmem_address, 16'h2000);
        chk128("wr_wdata",      bus.pmem_wdata, w12);
        tick;
        chk1("wr_no_early_resp", bus.d_resp, 1'b0);
        resp_on('0);
        chk1("wr_d_resp", bus.d_resp, 1'b1);
        tick;
        bus.pmem_resp = 0; bus.d_write = 0;
        tick;

        // Abandoned request
        bus.i_read = 1; bus.i_address = 16'h0100;
        tick;
        chk1("abandon_grant", bus.pmem_read, 1'b1);
        bus.i_read = 0;
        #1;
        chk1("abandon_strobe", bus.pmem_read, 1'b0);
        tick;
        chk1("abandon_idle", dut.state_q == arb_idle, 1'b1);

        // Reset mid-access
        bus.d_read = 1; bus.d_address = 16'h1800;
        tick;
        chk1("rm_granted", bus.pmem_read, 1'b1);
        reset = 1'b1;
        #1;
        chk1("rm_read_drop",  bus.pmem_read,  1'b0);
        chk1("rm_write_drop", bus.pmem_write, 1'b0);
        bus.d_read = 0;
        tick;
        reset = 1'b0;
        tick;
        resp_on(a5);
        chk1("rm_late_i_resp", bus.i_resp, 1'b0);
        chk1("rm_late_d_resp", bus.d_resp, 1'b0);
        tick;
        bus.pmem_resp = 0;

        // Protocol error: read wins, flag is sticky
        bus.d_read = 1; bus.d_write = 1; bus.d_address = 16'h3000;
        tick;
        chk1("pe_read",  bus.pmem_read,  1'b1);
        chk1("pe_write", bus.pmem_write, 1'b0);
        chk1("pe_flag",  bus.proto_err,  1'b1);
        resp_on(a5);
        tick;
        bus.pmem_resp = 0; bus.d_read = 0; bus.d_write = 0;
        tick; tick;
        chk1("pe_sticky", bus.proto_err, 1'b1);

        // Randomized traffic against the ordering rules
        run = 0;
        for (int it = 0; it < 40; it++) begin
            int       kind;
            bit       ip, dp, dw;
            logic [15:0] ia, da;
            lc3b_line wd;
            kind = $urandom_range(1, 3);
            ip = (kind & 1) != 0;
            dp = (kind & 2) != 0;
            dw = 1'($urandom);
            ia = 16'($urandom);
            da = 16'($urandom);
            wd = {$urandom, $urandom, $urandom, $urandom};
            bus.i_read = ip; bus.i_address = ia;
            bus.d_read = dp && !dw; bus.d_write = dp && dw;
            bus.d_address = da; bus.d_wdata = wd;
            while (ip || dp) begin
                bit       gd;
                lc3b_line rd;
                if (ip && dp) begin
                    gd  = run < MAXS;
                    run = gd ? run + 1 : 0;
                end else begin
                    gd  = dp;
                    run = 0;
                end
                tick;
                chk16("rnd_addr", bus.pmem_address, gd ? da : ia);
                chk1 ("rnd_write", bus.pmem_write, gd && dw);
                chk1 ("rnd_read",  bus.pmem_read, !(gd && dw));
                if (gd && dw) chk128("rnd_wdata", bus.pmem_wdata, wd);
                repeat ($urandom_range(0, 3)) tick;
                rd = {$urandom, $urandom, $urandom, $urandom};
                resp_on(rd);
                chk1  ("rnd_i_resp", bus.i_resp, !gd);
                chk1  ("rnd_d_resp", bus.d_resp, gd);
                chk128("rnd_i_rdata", bus.i_rdata, gd ? '0 : rd);
                chk128("rnd_d_rdata", bus.d_rdata, gd ? rd : '0);
                tick;
                bus.pmem_resp = 0;
                if (gd) begin
                    dp = 0; bus.d_read = 0; bus.d_write = 0;
                end else begin
                    ip = 0; bus.i_read = 0;
                end
            end
        end
        tick;
        chk1("final_proto_err", bus.proto_err, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
